instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 70 +++++++
 rtl/instr_encoder_if.sv | 33 +++
 rtl/instr_encoder_sync_fifo.sv | 75 +++++++
 rtl/instr_encoder.sv | 70 +++++++
 tb/tb_instr_encoder.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared RV32 encoding definitions: op enumeration, opcode/funct constants and the
// instruction encoder used by the instruction encoder and the control decoder.
package instr_encoder_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned IMM_W   = 12;

    typedef logic [INSTR_W-1:0] instr_t;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_MUL  = 4'd4,
        OP_ADDI = 4'd5,
        OP_SRAI = 4'd6,
        OP_LW   = 4'd7,
        OP_SW   = 4'd8,
        OP_BEQ  = 4'd9
    } op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return op <= OP_BEQ;
    endfunction

    // imm carries offset[12:1] for BEQ, so imm[11] is offset[12] and imm[10] is offset[11]
    function automatic instr_t encode(input logic [OP_W-1:0]  op,
                                      input logic [REG_W-1:0] rd,
                                      input logic [REG_W-1:0] rs1,
                                      input logic [REG_W-1:0] rs2,
                                      input logic [IMM_W-1:0] imm);
        instr_t w;
        w = '0;
        case (op)
            OP_ADD:  w = {F7_BASE, rs2, rs1, F3_ADD, rd, OPC_OP};
            OP_SUB:  w = {F7_ALT,  rs2, rs1, F3_ADD, rd, OPC_OP};
            OP_AND:  w = {F7_BASE, rs2, rs1, F3_AND, rd, OPC_OP};
            OP_OR:   w = {F7_BASE, rs2, rs1, F3_OR,  rd, OPC_OP};
            OP_MUL:  w = {F7_MUL,  rs2, rs1, F3_ADD, rd, OPC_OP};
            OP_ADDI: w = {imm, rs1, F3_ADD, rd, OPC_OP_IMM};
            OP_SRAI: w = {F7_ALT, imm[4:0], rs1, F3_SR, rd, OPC_OP_IMM};
            OP_LW:   w = {imm, rs1, F3_W, rd, OPC_LOAD};
            OP_SW:   w = {imm[11:5], rs2, rs1, F3_W, imm[4:0], OPC_STORE};
            OP_BEQ:  w = {imm[11], imm[9:4], rs2, rs1, F3_BEQ, imm[3:0], imm[10], OPC_BRANCH};
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bus of the instruction encoder.
interface instr_encoder_if #(
    parameter int unsigned DEPTH = 4
);
    import instr_encoder_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic              in_valid_i;
    logic              in_ready_o;
    logic [OP_W-1:0]   op_i;
    logic [REG_W-1:0]  rd_i;
    logic [REG_W-1:0]  rs1_i;
    logic [REG_W-1:0]  rs2_i;
    logic [IMM_W-1:0]  imm_i;
    logic              mem_we_o;
    logic              mem_ready_i;
    logic [31:0]       mem_addr_o;
    instr_t            mem_data_o;
    logic [CW-1:0]     count_o;
    logic              err_o;

    modport master (
        output in_valid_i, op_i, rd_i, rs1_i, rs2_i, imm_i, mem_ready_i,
        input  in_ready_o, mem_we_o, mem_addr_o, mem_data_o, count_o, err_o
    );

    modport slave (
        input  in_valid_i, op_i, rd_i, rs1_i, rs2_i, imm_i, mem_ready_i,
        output in_ready_o, mem_we_o, mem_addr_o, mem_data_o, count_o, err_o
    );

endinterface

// File: rtl/instr_encoder_sync_fifo.sv
// Synchronous FIFO with flush; head entry is presented from the storage registers.
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;

    // Flush wins over any push/pop in the same cycle
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction requests into RV32 words and streams them to instruction
// memory through an output buffer, one write per accepted memory handshake.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    instr_encoder_if.slave  bus
);

    logic        full, empty;
    logic        accept, legal, push, pop;
    instr_t      enc_word;
    logic [31:0] addr_q, addr_d;
    logic        err_q, err_d;

    assign bus.in_ready_o = !full;
    assign bus.mem_we_o   = !empty;
    assign bus.mem_addr_o = addr_q;
    assign bus.err_o      = err_q;

    assign accept   = bus.in_valid_i && !full;
    assign legal    = op_legal(bus.op_i);
    assign push     = accept && legal;
    assign pop      = !empty && bus.mem_ready_i;
    assign enc_word = encode(bus.op_i, bus.rd_i, bus.rs1_i, bus.rs2_i, bus.imm_i);

    // Address advances per completed write; flush also suppresses the error pulse
    always_comb begin
        addr_d = addr_q;
        err_d  = 1'b0;
        if (flush_i) begin
            addr_d = BASE_ADDR;
        end else begin
            if (pop) addr_d = addr_q + 32'd4;
            err_d = accept && !legal;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= BASE_ADDR;
            err_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            err_q  <= err_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (push),
        .data_i  (enc_word),
        .pop_i   (pop),
        .data_o  (bus.mem_data_o),
        .full_o  (full),
        .empty_o (empty),
        .count_o (bus.count_o)
    );

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench: directed scenarios then random traffic against a queue model.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam int unsigned DEPTH     = 4;
    localparam logic [31:0] WRAP_BASE = 32'hFFFF_FFFC;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [31:0] exp_q[$];
    logic [31:0] addr_off;
    logic        exp_err;

    always #5 clk = ~clk;

    instr_encoder_if #(.DEPTH(DEPTH)) bif ();
    instr_encoder_if #(.DEPTH(DEPTH)) wif ();

    assign wif.in_valid_i  = bif.in_valid_i;
    assign wif.op_i        = bif.op_i;
    assign wif.rd_i        = bif.rd_i;
    assign wif.rs1_i       = bif.rs1_i;
    assign wif.rs2_i       = bif.rs2_i;
    assign wif.imm_i       = bif.imm_i;
    assign wif.mem_ready_i = bif.mem_ready_i;

    instr_encoder #(.DEPTH(DEPTH)) u_dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bif.slave)
    );

    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(WRAP_BASE)) u_dut_wrap (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (wif.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference encoding built from the RV32 field layout with plain arithmetic
    function automatic logic [31:0] ref_word(input int unsigned op, input int unsigned rd,
                                             input int unsigned rs1, input int unsigned rs2,
                                             input int unsigned imm);
        int unsigned r_f7 [5] = '{0, 32, 0, 0, 1};
        int unsigned r_f3 [5] = '{0, 0, 7, 6, 0};
        logic [12:0] off;
        logic [31:0] w;
        w = '0;
        case (op)
            0, 1, 2, 3, 4: w = 32'((r_f7[op] << 25) + (rs2 << 20) + (rs1 << 15) + (r_f3[op] << 12) + (rd << 7) + 'h33);
            5: w = 32'((imm << 20) + (rs1 << 15) + (rd << 7) + 'h13);
            6: w = 32'((32'h20 << 25) + ((imm % 32) << 20) + (rs1 << 15) + (5 << 12) + (rd << 7) + 'h13);
            7: w = 32'((imm << 20) + (rs1 << 15) + (2 << 12) + (rd << 7) + 'h03);
            8: w = 32'(((imm / 32) << 25) + (rs2 << 20) + (rs1 << 15) + (2 << 12) + ((imm % 32) << 7) + 'h23);
            9: begin
                off = 13'(imm * 2);
                w = 32'((rs2 << 20) + (rs1 << 15) + 'h63);
                w[31]    = off[12];
                w[30:25] = off[10:5];
                w[11:8]  = off[4:1];
                w[7]     = off[11];
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    task automatic check_state();
        int unsigned sz;
        sz = exp_q.size();
        check("count",  32'(bif.count_o),    32'(sz));
        check("ready",  32'(bif.in_ready_o), 32'(sz < DEPTH));
        check("we",     32'(bif.mem_we_o),   32'(sz != 0));
        check("err",    32'(bif.err_o),      32'(exp_err));
        check("addr",   bif.mem_addr_o,      addr_off);
        check("waddr",  wif.mem_addr_o,      WRAP_BASE + addr_off);
        check("wcount", 32'(wif.count_o),    32'(sz));
        if (sz != 0) check("data", bif.mem_data_o, exp_q[0]);
    endtask

    // Drive one cycle of inputs, advance the model, then sample after the edge
    task automatic cycle(input logic v, input int unsigned op, input int unsigned rd,
                         input int unsigned rs1, input int unsigned rs2, input int unsigned imm,
                         input logic mr, input logic fl);
        bit acc, legal, pop;
        bif.in_valid_i  = v;
        bif.op_i        = 4'(op);
        bif.rd_i        = 5'(rd);
        bif.rs1_i       = 5'(rs1);
        bif.rs2_i       = 5'(rs2);
        bif.imm_i       = 12'(imm);
        bif.mem_ready_i = mr;
        flush           = fl;
        acc   = v && (exp_q.size() < DEPTH);
        legal = op <= 9;
        pop   = (exp_q.size() > 0) && mr;
        if (fl) begin
            exp_q.delete();
            addr_off = '0;
            exp_err  = 1'b0;
        end else begin
            if (pop) begin
                void'(exp_q.pop_front());
                addr_off = addr_off + 32'd4;
            end
            if (acc && legal) exp_q.push_back(ref_word(op, rd, rs1, rs2, imm));
            exp_err = acc && !legal;
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic idle(input logic mr);
        cycle(1'b0, 0, 0, 0, 0, 0, mr, 1'b0);
    endtask

    // Asynchronous reset in the middle of a cycle, visible before the next edge
    task automatic do_reset();
        bif.in_valid_i = 1'b0;
        flush          = 1'b0;
        rst            = 1'b1;
        exp_q.delete();
        addr_off = '0;
        exp_err  = 1'b0;
        #2;
        check_state();
        check("rst_data", bif.mem_data_o, 32'h0);
        @(posedge clk);
        #1;
        check_state();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] stream [4] = '{32'hFFF0_0293, 32'h0061_2423, 32'h0020_8463, 32'h4052_5193};
        bif.in_valid_i  = 1'b0;
        bif.op_i        = '0;
        bif.rd_i        = '0;
        bif.rs1_i       = '0;
        bif.rs2_i       = '0;
        bif.imm_i       = '0;
        bif.mem_ready_i = 1'b0;
        exp_err         = 1'b0;
        addr_off        = '0;

        repeat (2) @(posedge clk);
        #1;
        check_state();
        check("rst_data", bif.mem_data_o, 32'h0);
        check("rst_ready", 32'(bif.in_ready_o), 32'h1);
        rst = 1'b0;

        // Single ADD, memory always ready
        cycle(1'b1, 0, 1, 2, 3, 0, 1'b1, 1'b0);
        check("add_data", bif.mem_data_o, 32'h0031_00B3);
        check("add_addr", bif.mem_addr_o, 32'h0);
        check("wrap_addr0", wif.mem_addr_o, 32'hFFFF_FFFC);
        idle(1'b1);
        check("add_done", 32'(bif.count_o), 32'h0);
        check("wrap_addr1", wif.mem_addr_o, 32'h0);
        cycle(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b1);

        // Four-entry stream with memory stalled, then a fifth held off
        cycle(1'b1, 5, 5, 0, 0, 'hFFF, 1'b0, 1'b0);
        cycle(1'b1, 8, 0, 2, 6, 8, 1'b0, 1'b0);
        cycle(1'b1, 9, 0, 1, 2, 4, 1'b0, 1'b0);
        cycle(1'b1, 6, 3, 4, 0, 5, 1'b0, 1'b0);
        check("full_count", 32'(bif.count_o), 32'd4);
        check("full_ready", 32'(bif.in_ready_o), 32'd0);
        cycle(1'b1, 0, 7, 7, 7, 0, 1'b0, 1'b0);
        check("held_count", 32'(bif.count_o), 32'd4);
        check("held_data", bif.mem_data_o, 32'hFFF0_0293);
        for (int k = 0; k < 4; k++) begin
            check("stream_data", bif.mem_data_o, stream[k]);
            check("stream_addr", bif.mem_addr_o, 32'(4 * k));
            idle(1'b1);
        end

        // Illegal op on an empty buffer
        cycle(1'b1, 12, 1, 1, 1, 1, 1'b1, 1'b0);
        check("ill_err", 32'(bif.err_o), 32'd1);
        check("ill_we", 32'(bif.mem_we_o), 32'd0);
        idle(1'b1);
        check("ill_err_end", 32'(bif.err_o), 32'd0);

        // Flush with three buffered entries at address 8
        cycle(0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
        cycle(1'b1, 1, 1, 2, 3, 0, 1'b0, 1'b0);
        cycle(1'b1, 2, 4, 5, 6, 0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        cycle(1'b1, 3, 1, 1, 1, 0, 1'b0, 1'b0);
        cycle(1'b1, 4, 2, 2, 2, 0, 1'b0, 1'b0);
        cycle(1'b1, 7, 3, 3, 3, 'h10, 1'b0, 1'b0);
        check("pre_flush_addr", bif.mem_addr_o, 32'h8);
        check("pre_flush_cnt", 32'(bif.count_o), 32'd3);
        cycle(1'b1, 0, 5, 5, 5, 0, 1'b1, 1'b1);
        check("flush_cnt", 32'(bif.count_o), 32'd0);
        check("flush_addr", bif.mem_addr_o, 32'h0);
        cycle(1'b1, 5, 9, 1, 0, 7, 1'b0, 1'b0);
        check("post_flush_addr", bif.mem_addr_o, 32'h0);
        check("post_flush_data", bif.mem_data_o, 32'h0070_8493);

        // Reset while entries are pending
        cycle(1'b1, 0, 1, 1, 1, 0, 1'b0, 1'b0);
        do_reset();

        // Random traffic with varying memory back-pressure
        for (int i = 0; i < 800; i++) begin
            int unsigned op;
            logic mr;
            op = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            mr = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cycle($urandom_range(0, 3) != 0, op, $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 4095), mr, $urandom_range(0, 40) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
